// File: rtl/vend_pkg.sv
// Shared vending types: FSM states, error codes, stock record layout, limits.
// Pure declarations; no latency, no backpressure.
package vend_pkg;
    localparam int NSLOT   = 8;
    localparam int MAX_VAL = 15;

    localparam int ID_MSB    = 10;
    localparam int ID_LSB    = 8;
    localparam int STOCK_MSB = 7;
    localparam int STOCK_LSB = 4;
    localparam int PRICE_MSB = 3;
    localparam int PRICE_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CREDIT,
        S_CHECK,
        S_DISPENSE,
        S_CHANGE,
        S_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_STOCK = 2'd1;
    localparam logic [1:0] ERR_FUNDS = 2'd2;
    localparam logic [1:0] ERR_CASH  = 2'd3;
endpackage

// File: rtl/vend_stock_table.sv
// 8x11 slot record table: one synchronous write port, combinational read.
// Writes visible on the next cycle; no backpressure.
module vend_stock_table
    import vend_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic        i_we,
    input  logic [2:0]  i_waddr,
    input  logic [10:0] i_wdata,
    input  logic [2:0]  i_raddr,
    output logic [10:0] o_rdata
);
    logic [10:0] r_mem [NSLOT];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NSLOT; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/vend_sequencer.sv
// Vending sequencer: coin credit, one-cycle stock/funds check, dispense and change handshakes.
// All outputs registered; disp/change outputs hold until their ready handshake.
module vend_sequencer
    import vend_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic        coin_valid,
    input  logic [3:0]  coin_value,
    output logic        coin_reject,
    input  logic        sel_valid,
    input  logic [2:0]  sel_mode,
    input  logic [3:0]  sel_qty,
    input  logic        cancel,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [10:0] cfg_data,
    output logic        disp_valid,
    input  logic        disp_ready,
    output logic [10:0] product,
    output logic [3:0]  disp_count,
    output logic        change_valid,
    input  logic        change_ready,
    output logic [3:0]  change_amt,
    output logic        redlight,
    output logic [1:0]  err_code,
    output logic [3:0]  credit,
    output logic [3:0]  cash,
    output logic        busy
);
    state_t      r_state, w_state;
    logic [3:0]  r_credit, w_credit, r_cash, w_cash;
    logic [2:0]  r_mode, w_mode;
    logic [3:0]  r_qty, w_qty, r_cost, w_cost_q;
    logic        r_coin_reject, w_coin_reject, r_disp_valid, w_disp_valid;
    logic [10:0] r_product, w_product;
    logic [3:0]  r_disp_count, w_disp_count, r_change_amt, w_change_amt;
    logic        r_change_valid, w_change_valid, r_redlight, w_redlight, r_busy, w_busy;
    logic [1:0]  r_err, w_err;

    logic [10:0] w_rec;
    logic [3:0]  w_stock, w_price;
    logic [4:0]  w_dq, w_coin_sum;
    logic [7:0]  w_cost;
    logic [8:0]  w_cash_sum;
    logic        w_tbl_we;
    logic [2:0]  w_tbl_waddr;
    logic [10:0] w_tbl_wdata;

    assign w_tbl_we    = (r_state == S_IDLE && cfg_we) || (r_state == S_DISPENSE && disp_ready);
    assign w_tbl_waddr = (r_state == S_IDLE) ? cfg_addr : r_mode;
    assign w_tbl_wdata = (r_state == S_IDLE) ? cfg_data : r_product;

    vend_stock_table u_table (
        .clock   (clock),
        .resetn  (resetn),
        .i_we    (w_tbl_we),
        .i_waddr (w_tbl_waddr),
        .i_wdata (w_tbl_wdata),
        .i_raddr (r_mode),
        .o_rdata (w_rec)
    );

    assign w_stock    = w_rec[STOCK_MSB:STOCK_LSB];
    assign w_price    = w_rec[PRICE_MSB:PRICE_LSB];
    // Two or more units earn one free extra unit.
    assign w_dq       = (r_qty >= 4'd2) ? ({1'b0, r_qty} + 5'd1) : {1'b0, r_qty};
    assign w_cost     = {4'd0, w_price} * {4'd0, r_qty};
    assign w_cash_sum = {5'd0, r_cash} + {1'b0, w_cost};
    assign w_coin_sum = {1'b0, r_credit} + {1'b0, coin_value};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state        <= S_IDLE;
            r_credit       <= '0;
            r_cash         <= '0;
            r_mode         <= '0;
            r_qty          <= '0;
            r_cost         <= '0;
            r_coin_reject  <= 1'b0;
            r_disp_valid   <= 1'b0;
            r_product      <= '0;
            r_disp_count   <= '0;
            r_change_valid <= 1'b0;
            r_change_amt   <= '0;
            r_redlight     <= 1'b0;
            r_err          <= ERR_NONE;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_credit       <= w_credit;
            r_cash         <= w_cash;
            r_mode         <= w_mode;
            r_qty          <= w_qty;
            r_cost         <= w_cost_q;
            r_coin_reject  <= w_coin_reject;
            r_disp_valid   <= w_disp_valid;
            r_product      <= w_product;
            r_disp_count   <= w_disp_count;
            r_change_valid <= w_change_valid;
            r_change_amt   <= w_change_amt;
            r_redlight     <= w_redlight;
            r_err          <= w_err;
            r_busy         <= w_busy;
        end
    end

    always_comb begin
        w_state        = r_state;
        w_credit       = r_credit;
        w_cash         = r_cash;
        w_mode         = r_mode;
        w_qty          = r_qty;
        w_cost_q       = r_cost;
        w_coin_reject  = coin_valid;
        w_disp_valid   = r_disp_valid;
        w_product      = r_product;
        w_disp_count   = r_disp_count;
        w_change_valid = r_change_valid;
        w_change_amt   = r_change_amt;
        w_redlight     = r_redlight;
        w_err          = r_err;
        case (r_state)
            S_IDLE, S_CREDIT: begin
                if (sel_valid) begin
                    w_mode     = sel_mode;
                    w_qty      = sel_qty;
                    w_redlight = 1'b0;
                    w_err      = ERR_NONE;
                    if (sel_qty == 4'd0) begin
                        w_state    = S_ERROR;
                        w_redlight = 1'b1;
                        w_err      = ERR_FUNDS;
                    end else begin
                        w_state = S_CHECK;
                    end
                end else if (cancel && r_state == S_CREDIT) begin
                    w_state        = S_CHANGE;
                    w_change_valid = 1'b1;
                    w_change_amt   = r_credit;
                end else if (coin_valid && w_coin_sum <= 5'(MAX_VAL)) begin
                    w_credit      = w_coin_sum[3:0];
                    w_coin_reject = 1'b0;
                    if (w_coin_sum != 5'd0) w_state = S_CREDIT;
                end
            end
            S_CHECK: begin
                w_cost_q = w_cost[3:0];
                if ({1'b0, w_stock} < w_dq) begin
                    w_state = S_ERROR; w_redlight = 1'b1; w_err = ERR_STOCK;
                end else if (w_cost > {4'd0, r_credit}) begin
                    w_state = S_ERROR; w_redlight = 1'b1; w_err = ERR_FUNDS;
                end else if (w_cash_sum > 9'(MAX_VAL)) begin
                    w_state = S_ERROR; w_redlight = 1'b1; w_err = ERR_CASH;
                end else begin
                    w_state      = S_DISPENSE;
                    w_disp_valid = 1'b1;
                    w_disp_count = w_dq[3:0];
                    w_product    = {w_rec[ID_MSB:ID_LSB], w_stock - w_dq[3:0], w_price};
                end
            end
            S_DISPENSE: begin
                if (disp_ready) begin
                    w_disp_valid = 1'b0;
                    w_credit     = r_credit - r_cost;
                    w_cash       = r_cash + r_cost;
                    if (w_credit != 4'd0) begin
                        w_state        = S_CHANGE;
                        w_change_valid = 1'b1;
                        w_change_amt   = w_credit;
                    end else begin
                        w_state = S_IDLE;
                    end
                end
            end
            S_CHANGE: begin
                if (change_ready) begin
                    w_credit       = '0;
                    w_change_valid = 1'b0;
                    w_change_amt   = '0;
                    w_state        = S_IDLE;
                end
            end
            S_ERROR: w_state = (r_credit != 4'd0) ? S_CREDIT : S_IDLE;
            default: w_state = S_IDLE;
        endcase
        w_busy = !(w_state == S_IDLE || w_state == S_CREDIT);
    end

    assign coin_reject  = r_coin_reject;
    assign disp_valid   = r_disp_valid;
    assign product      = r_product;
    assign disp_count   = r_disp_count;
    assign change_valid = r_change_valid;
    assign change_amt   = r_change_amt;
    assign redlight     = r_redlight;
    assign err_code     = r_err;
    assign credit       = r_credit;
    assign cash         = r_cash;
    assign busy         = r_busy;
endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: inputs driven and outputs sampled 1ns after each rising edge.
module tb_vend_sequencer;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        coin_valid = 1'b0;
    logic [3:0]  coin_value = '0;
    logic        coin_reject;
    logic        sel_valid = 1'b0;
    logic [2:0]  sel_mode = '0;
    logic [3:0]  sel_qty = '0;
    logic        cancel = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [10:0] cfg_data = '0;
    logic        disp_valid;
    logic        disp_ready = 1'b0;
    logic [10:0] product;
    logic [3:0]  disp_count;
    logic        change_valid;
    logic        change_ready = 1'b0;
    logic [3:0]  change_amt;
    logic        redlight;
    logic [1:0]  err_code;
    logic [3:0]  credit;
    logic [3:0]  cash;
    logic        busy;

    int tests = 0;
    int fails = 0;

    vend_sequencer dut (
        .clock(clock), .resetn(resetn),
        .coin_valid(coin_valid), .coin_value(coin_value), .coin_reject(coin_reject),
        .sel_valid(sel_valid), .sel_mode(sel_mode), .sel_qty(sel_qty), .cancel(cancel),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .product(product),
        .disp_count(disp_count), .change_valid(change_valid), .change_ready(change_ready),
        .change_amt(change_amt), .redlight(redlight), .err_code(err_code),
        .credit(credit), .cash(cash), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic restock(input logic [2:0] a, input logic [2:0] id, input logic [3:0] st,
                           input logic [3:0] pr);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = {id, st, pr};
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic coin(input logic [3:0] v);
        coin_valid = 1'b1; coin_value = v;
        tick();
        coin_valid = 1'b0; coin_value = '0;
    endtask

    task automatic sel(input logic [2:0] m, input logic [3:0] q);
        sel_valid = 1'b1; sel_mode = m; sel_qty = q;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic pulse_disp();
        disp_ready = 1'b1; tick(); disp_ready = 1'b0;
    endtask

    task automatic pulse_change();
        change_ready = 1'b1; tick(); change_ready = 1'b0;
    endtask

    task automatic pulse_cancel();
        cancel = 1'b1; tick(); cancel = 1'b0;
    endtask

    initial begin
        tick(); tick();
        chk("rst_credit", credit, 0);
        chk("rst_cash", cash, 0);
        chk("rst_busy", busy, 0);
        chk("rst_disp_valid", disp_valid, 0);
        chk("rst_change_valid", change_valid, 0);
        chk("rst_redlight", redlight, 0);
        resetn = 1'b1;
        tick();

        // basic vend with gift unit and change
        restock(3'd3, 3'd3, 4'd5, 4'd2);
        coin(4'd4);
        chk("s1_credit4", credit, 4);
        chk("s1_idle_busy", busy, 0);
        coin(4'd3);
        chk("s1_credit7", credit, 7);
        sel(3'd3, 4'd2);
        chk("s1_check_busy", busy, 1);
        tick();
        chk("s1_disp_valid", disp_valid, 1);
        chk("s1_disp_count", disp_count, 3);
        chk("s1_product", product, {3'd3, 4'd2, 4'd2});
        chk("s1_credit_hold", credit, 7);
        pulse_disp();
        chk("s1_disp_done", disp_valid, 0);
        chk("s1_credit3", credit, 3);
        chk("s1_cash4", cash, 4);
        chk("s1_change_valid", change_valid, 1);
        chk("s1_change_amt", change_amt, 3);
        pulse_change();
        chk("s1_change_done", change_valid, 0);
        chk("s1_credit0", credit, 0);
        chk("s1_idle", busy, 0);
        chk("s1_redlight", redlight, 0);

        // coin overflow rejected
        coin(4'd12);
        chk("s2_credit12", credit, 12);
        coin(4'd5);
        chk("s2_reject", coin_reject, 1);
        chk("s2_credit_kept", credit, 12);
        tick();
        chk("s2_reject_pulse", coin_reject, 0);

        // out of stock: slot 3 now holds 2 units, dq=3
        sel(3'd3, 4'd2);
        tick();
        chk("s3_redlight", redlight, 1);
        chk("s3_err", err_code, 1);
        chk("s3_err_busy", busy, 1);
        chk("s3_credit", credit, 12);
        tick();
        chk("s3_back_credit", busy, 0);
        chk("s3_red_hold", redlight, 1);
        pulse_cancel();
        chk("s3_cancel_change", change_valid, 1);
        chk("s3_cancel_amt", change_amt, 12);
        pulse_change();
        chk("s3_refund_credit", credit, 0);

        // insufficient funds, then top up and succeed
        do_reset();
        restock(3'd5, 3'd5, 4'd9, 4'd4);
        coin(4'd10);
        chk("s4_red_before_sel", redlight, 0);
        sel(3'd5, 4'd3);
        tick();
        chk("s4_err_funds", err_code, 2);
        chk("s4_red_funds", redlight, 1);
        tick();
        chk("s4_credit_kept", credit, 10);
        chk("s4_back_credit", busy, 0);
        coin(4'd2);
        chk("s4_credit12", credit, 12);
        sel(3'd5, 4'd3);
        chk("s4_red_cleared", redlight, 0);
        chk("s4_err_cleared", err_code, 0);
        tick();
        chk("s4_disp_count", disp_count, 4);
        chk("s4_product", product, {3'd5, 4'd5, 4'd4});
        pulse_disp();
        chk("s4_cash12", cash, 12);
        chk("s4_credit0", credit, 0);
        chk("s4_no_change", change_valid, 0);
        chk("s4_idle", busy, 0);
        chk("s4_red_ok", redlight, 0);

        // machine cash full
        restock(3'd1, 3'd1, 4'd9, 4'd1);
        coin(4'd2);
        sel(3'd1, 4'd2);
        tick();
        chk("s5_disp1", disp_valid, 1);
        pulse_disp();
        chk("s5_cash14", cash, 14);
        coin(4'd2);
        sel(3'd1, 4'd2);
        tick();
        chk("s5_err_cash", err_code, 3);
        chk("s5_red_cash", redlight, 1);
        chk("s5_cash_kept", cash, 14);
        tick();
        chk("s5_credit2", credit, 2);
        pulse_cancel();
        pulse_change();

        // quantity zero goes straight to ERROR
        coin(4'd5);
        sel(3'd1, 4'd0);
        chk("q0_err", err_code, 2);
        chk("q0_busy", busy, 1);
        tick();
        chk("q0_back", busy, 0);
        pulse_cancel();
        pulse_change();

        // stalled dispense, then reset in DISPENSE
        do_reset();
        restock(3'd2, 3'd2, 4'd8, 4'd3);
        coin(4'd6);
        sel(3'd2, 4'd1);
        tick();
        chk("s6_product", product, {3'd2, 4'd7, 4'd3});
        coin_valid = 1'b1; coin_value = 4'd1; cancel = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("s6_stall_valid", disp_valid, 1);
            chk("s6_stall_product", product, {3'd2, 4'd7, 4'd3});
            chk("s6_stall_count", disp_count, 1);
            chk("s6_stall_reject", coin_reject, 1);
            chk("s6_stall_credit", credit, 6);
        end
        coin_valid = 1'b0; coin_value = '0; cancel = 1'b0;
        resetn = 1'b0;
        #2;
        chk("s6_rst_valid", disp_valid, 0);
        chk("s6_rst_product", product, 0);
        chk("s6_rst_count", disp_count, 0);
        chk("s6_rst_credit", credit, 0);
        chk("s6_rst_cash", cash, 0);
        chk("s6_rst_busy", busy, 0);
        tick();
        resetn = 1'b1;
        tick();
        coin(4'd5);
        restock(3'd2, 3'd2, 4'd8, 4'd3);
        sel(3'd2, 4'd1);
        tick();
        chk("s6_table_cleared", err_code, 1);
        chk("s6_no_disp", disp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
